lzc_normalizer_16: RTL and testbench

//  Upstream stage of the 16-bit left barrel shifter (floating/fixed-point normalize path).

---
 rtl/lzc_normalizer_16.sv | 153 +++++++++++++++
 tb/tb_lzc_normalizer_16.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/lzc_normalizer_16.sv
// lzc_normalizer_16
// Leading-zero counter in front of the 16-bit left barrel shifter on the
// normalize path. It accepts one operand through a valid/ready handshake.
// It finds the leading-zero count with a four-step binary search (8, 4, 2, 1),
// one step per clock. It then presents the original operand (Ip) and the
// count (shift_mag), ready to drive the shifter directly.
// Optional feature: define LZC_NORM_OUT_EN to expose the final normalized
// word as norm_out, so the consumer can cross-check the shifter's output.
module lzc_normalizer_16 #(
  parameter int DATA_W  = 16,
  parameter int SHIFT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] Ip,
  output logic [SHIFT_W-1:0] shift_mag,
  output logic              zero
`ifdef LZC_NORM_OUT_EN
  ,
  output logic [DATA_W-1:0] norm_out
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_W-1:0]    work_q, work_d;
  logic [DATA_W-1:0]    ip_q, ip_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [1:0]           step_q, step_d;
  logic                 zero_q, zero_d;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 top_zero_s;
  logic [SHIFT_W-1:0]   n_s;

  // Next-state logic: capture in IDLE, one binary-search step per SCAN cycle, hold in DONE.
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    ip_d       = ip_q;
    shift_d    = shift_q;
    step_d     = step_q;
    zero_d     = zero_q;
    top_zero_s = 1'b0;
    n_s        = SHIFT_W'(0);
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          ip_d    = in_data;
          work_d  = in_data;
          shift_d = SHIFT_W'(0);
          step_d  = 2'd3;
          if (in_data == DATA_W'(0)) begin
            zero_d  = 1'b1;
            state_d = DONE;
          end else begin
            zero_d  = 1'b0;
            state_d = SCAN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        // Window width n = 2^step: test whether the top n bits are all zero.
        case (step_q)
          2'd3: begin
            n_s        = SHIFT_W'(8);
            top_zero_s = (work_q[DATA_W-1 -: 8] == 8'd0);
          end
          2'd2: begin
            n_s        = SHIFT_W'(4);
            top_zero_s = (work_q[DATA_W-1 -: 4] == 4'd0);
          end
          2'd1: begin
            n_s        = SHIFT_W'(2);
            top_zero_s = (work_q[DATA_W-1 -: 2] == 2'd0);
          end
          default: begin
            n_s        = SHIFT_W'(1);
            top_zero_s = (work_q[DATA_W-1] == 1'b0);
          end
        endcase
        if (top_zero_s) begin
          work_d  = work_q << n_s;
          shift_d = shift_q + n_s;
        end else begin
          work_d  = work_q;
          shift_d = shift_q;
        end
        step_d = step_q - 2'd1;
        if (step_q == 2'd0) begin
          state_d = DONE;
        end else begin
          state_d = SCAN;
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; handshake flags are registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      work_q      <= DATA_W'(0);
      ip_q        <= DATA_W'(0);
      shift_q     <= SHIFT_W'(0);
      step_q      <= 2'd0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      ip_q        <= ip_d;
      shift_q     <= shift_d;
      step_q      <= step_d;
      zero_q      <= zero_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Ip        = ip_q;
  assign shift_mag = shift_q;
  assign zero      = zero_q;
`ifdef LZC_NORM_OUT_EN
  assign norm_out  = work_q;
`endif

endmodule

// File: tb/tb_lzc_normalizer_16.sv
// Randomized bench for lzc_normalizer_16 with a behavioural barrel-shifter
// stage downstream. It checks directed corner operands, backpressure,
// mid-scan reset and 1000 random operands against a reference leading-zero model.
module tb_lzc_normalizer_16;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Ip;
  logic [3:0]  shift_mag;
  logic        zero;
`ifdef LZC_NORM_OUT_EN
  logic [15:0] norm_out;
`endif

  int checks = 0;
  int errors = 0;

  lzc_normalizer_16 dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Ip       (Ip),
    .shift_mag(shift_mag),
    .zero     (zero)
`ifdef LZC_NORM_OUT_EN
    ,
    .norm_out (norm_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: count leading zeros by repeated doubling until the MSB is set.
  function automatic int ref_lzc(input logic [15:0] d);
    int v;
    int n;
    v = int'(d);
    n = 0;
    if (v == 0) return 0;
    while (v < 32768) begin
      v = v * 2;
      n++;
    end
    return n;
  endfunction

  // Send one operand, check the result, hold it for 'hold' cycles, then release it.
  task automatic run_op(input logic [15:0] d, input int hold);
    int          lat;
    int          exp_lz;
    int          exp_lat;
    logic [15:0] op;
    logic [15:0] exp_norm;
    exp_lz   = ref_lzc(d);
    exp_lat  = (d == 16'h0000) ? 1 : 5;
    exp_norm = 16'((32'(d) * (32'd1 << exp_lz)) & 32'hFFFF);
    out_ready = 1'b0;
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < 20) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 16'($urandom());
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
    check("out_valid", {31'd0, out_valid}, 32'd1);
    check("Ip", {16'd0, Ip}, {16'd0, d});
    check("shift_mag", {28'd0, shift_mag}, 32'(exp_lz));
    check("zero", {31'd0, zero}, {31'd0, (d == 16'h0000)});
    op = Ip << shift_mag;
    if (d != 16'h0000) check("op_msb", {31'd0, op[15]}, 32'd1);
    check("op_value", {16'd0, op}, {16'd0, exp_norm});
`ifdef LZC_NORM_OUT_EN
    check("norm_out", {16'd0, norm_out}, {16'd0, exp_norm});
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_shift", {28'd0, shift_mag}, 32'(exp_lz));
      check("hold_Ip", {16'd0, Ip}, {16'd0, d});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", {31'd0, out_valid}, 32'd0);
    check("release_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [15:0] r;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_Ip", {16'd0, Ip}, 32'd0);
    check("rst_shift", {28'd0, shift_mag}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
`ifdef LZC_NORM_OUT_EN
    check("rst_norm", {16'd0, norm_out}, 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);

    // Directed corner operands.
    run_op(16'h0001, 0);
    run_op(16'h8000, 0);
    run_op(16'h00F0, 0);
    run_op(16'h0300, 0);
    run_op(16'h0000, 0);
    run_op(16'h0000, 3);
    run_op(16'h0040, 10);

    // Reset during the second SCAN cycle of 0x0004.
    in_valid = 1'b1;
    in_data  = 16'h0004;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_shift", {28'd0, shift_mag}, 32'd0);
    check("mid_rst_Ip", {16'd0, Ip}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    run_op(16'h0004, 0);

    // Random operands spread across all leading-zero counts.
    for (int k = 0; k < 1000; k++) begin
      r = 16'($urandom() >> $urandom_range(16, 32));
      run_op(r, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
